dm_arbiter: RTL and testbench



---
 rtl/dm_arb_pkg.sv | 12 +
 rtl/dm_arb_pick.sv | 34 +++
 rtl/dm_arbiter.sv | 134 +++++++++++++
 tb/tb_dm_arbiter.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dm_arb_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RESP = 1'b1
  } state_e;

  localparam logic P_CPU = 1'b0;
  localparam logic P_DMA = 1'b1;

endpackage

// File: rtl/dm_arb_pick.sv
// Combinational two-way picker: round-robin or fixed priority, gated by an active lock.
module dm_arb_pick
  import dm_arb_pkg::*;
#(
  parameter int RR_EN = 1
) (
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  input  logic       lock_i,
  input  logic       lock_owner_i,
  output logic       win_o,
  output logic       vld_o
);

  always_comb begin
    win_o = P_CPU;
    vld_o = 1'b0;
    if (lock_i) begin
      // The non-owner is invisible while a locked sequence is open.
      win_o = lock_owner_i;
      vld_o = req_i[lock_owner_i];
    end else if (&req_i) begin
      vld_o = 1'b1;
      win_o = (RR_EN != 0) ? ~last_grant_i : P_CPU;
    end else if (req_i[0]) begin
      vld_o = 1'b1;
      win_o = P_CPU;
    end else if (req_i[1]) begin
      vld_o = 1'b1;
      win_o = P_DMA;
    end
  end

endmodule

// File: rtl/dm_arbiter.sv
// Two-port arbiter in front of a single-ported data memory (sync write, registered read).
module dm_arbiter
  import dm_arb_pkg::*;
#(
  parameter int RR_EN = 1,
  parameter int AW    = 10,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          we0,
  input  logic          lock0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          ack0,
  output logic [DW-1:0] rdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic          lock1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          ack1,
  output logic [DW-1:0] rdata1,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_din,
  output logic          m_we,
  input  logic [DW-1:0] m_dout,
  output logic          busy
);

  state_e        state_q, state_d;
  logic          owner_q, owner_d;
  logic          we_q, we_d;
  logic          lock_q, lock_d;
  logic          lock_owner_q, lock_owner_d;
  logic          last_grant_q, last_grant_d;
  logic [AW-1:0] addr_q;

  logic          win, win_vld, issue;
  logic          w_we, w_lock;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_wdata;

  dm_arb_pick #(.RR_EN(RR_EN)) u_pick (
    .req_i       ({req1, req0}),
    .last_grant_i(last_grant_q),
    .lock_i      (lock_q),
    .lock_owner_i(lock_owner_q),
    .win_o       (win),
    .vld_o       (win_vld)
  );

  assign w_we    = win ? we1    : we0;
  assign w_lock  = win ? lock1  : lock0;
  assign w_addr  = win ? addr1  : addr0;
  assign w_wdata = win ? wdata1 : wdata0;
  assign issue   = (state_q == S_IDLE) && win_vld;
  assign busy    = (state_q == S_RESP);

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    we_d         = we_q;
    lock_d       = lock_q;
    lock_owner_d = lock_owner_q;
    last_grant_d = last_grant_q;
    m_we         = 1'b0;
    m_addr       = '0;
    m_din        = '0;
    ack0         = 1'b0;
    ack1         = 1'b0;
    rdata0       = '0;
    rdata1       = '0;
    unique case (state_q)
      S_IDLE: begin
        if (win_vld) begin
          state_d      = S_RESP;
          owner_d      = win;
          we_d         = w_we;
          last_grant_d = win;
          // While locked the winner is always the lock owner, so lock=0 ends the sequence.
          if (!lock_q && w_lock) begin
            lock_d       = 1'b1;
            lock_owner_d = win;
          end else if (lock_q && !w_lock) begin
            lock_d = 1'b0;
          end
          // Gating with rst_n keeps the memory quiet the instant reset is asserted.
          if (rst_n) begin
            m_we   = w_we;
            m_addr = w_addr;
            m_din  = w_wdata;
          end
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        m_addr  = addr_q;
        if (owner_q == P_DMA) begin
          ack1 = 1'b1;
          if (!we_q) rdata1 = m_dout;
        end else begin
          ack0 = 1'b1;
          if (!we_q) rdata0 = m_dout;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      owner_q      <= P_CPU;
      we_q         <= 1'b0;
      lock_q       <= 1'b0;
      lock_owner_q <= P_CPU;
      last_grant_q <= P_DMA;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      we_q         <= we_d;
      lock_q       <= lock_d;
      lock_owner_q <= lock_owner_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_ff @(posedge clk) begin
    if (issue) addr_q <= w_addr;
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// Scoreboard bench for dm_arbiter: drivers push transactions, a negedge monitor checks them.
`timescale 1ns/1ps
module tb_dm_arbiter;
  localparam int AW = 10;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          req0 = 1'b0, we0 = 1'b0, lock0 = 1'b0;
  logic [AW-1:0] addr0 = '0;
  logic [DW-1:0] wdata0 = '0;
  logic          req1 = 1'b0, we1 = 1'b0, lock1 = 1'b0;
  logic [AW-1:0] addr1 = '0;
  logic [DW-1:0] wdata1 = '0;
  logic          ack0, ack1, m_we, busy;
  logic [DW-1:0] rdata0, rdata1, m_din;
  logic [DW-1:0] m_dout = '0;
  logic [AW-1:0] m_addr;

  dm_arbiter #(.RR_EN(1), .AW(AW), .DW(DW)) u_rr (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .we0(we0), .lock0(lock0), .addr0(addr0), .wdata0(wdata0),
    .ack0(ack0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .lock1(lock1), .addr1(addr1), .wdata1(wdata1),
    .ack1(ack1), .rdata1(rdata1),
    .m_addr(m_addr), .m_din(m_din), .m_we(m_we), .m_dout(m_dout), .busy(busy)
  );

  // Fixed-priority instance, exercised by its own directed stimulus.
  logic          f_req0 = 1'b0, f_req1 = 1'b0;
  logic          f_ack0, f_ack1, f_m_we, f_busy;
  logic [DW-1:0] f_rdata0, f_rdata1, f_m_din;
  logic [DW-1:0] f_m_dout = '0;
  logic [AW-1:0] f_m_addr;

  dm_arbiter #(.RR_EN(0), .AW(AW), .DW(DW)) u_fx (
    .clk(clk), .rst_n(rst_n),
    .req0(f_req0), .we0(1'b0), .lock0(1'b0), .addr0(10'd5), .wdata0(32'h0),
    .ack0(f_ack0), .rdata0(f_rdata0),
    .req1(f_req1), .we1(1'b0), .lock1(1'b0), .addr1(10'd9), .wdata1(32'h0),
    .ack1(f_ack1), .rdata1(f_rdata1),
    .m_addr(f_m_addr), .m_din(f_m_din), .m_we(f_m_we), .m_dout(f_m_dout), .busy(f_busy)
  );

  always @(posedge clk) f_m_dout <= {22'h0, f_m_addr};

  function automatic logic [DW-1:0] init_val(logic [AW-1:0] a);
    return {a, 22'h0} ^ 32'h5A5A_1234 ^ {22'h0, a};
  endfunction

  // Data memory: sync write, registered read.
  logic [DW-1:0] mem [1024];
  bit            mem_wr [1024];
  always @(posedge clk) begin
    m_dout <= mem_wr[m_addr] ? mem[m_addr] : init_val(m_addr);
    if (m_we) begin
      mem[m_addr]    <= m_din;
      mem_wr[m_addr] <= 1'b1;
    end
  end

  typedef struct {bit we; bit lk; logic [AW-1:0] a; logic [DW-1:0] d;} txn_t;
  typedef struct {int p; logic [DW-1:0] rd;} ack_t;
  txn_t q0[$];
  txn_t q1[$];
  ack_t alog[$];

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model state: access-level view of the arbiter.
  bit            ph = 1'b0;
  bit            locked = 1'b0;
  int            lockp = 0, lastw = 1, pend = 0;
  logic [DW-1:0] exp_rd;
  logic [AW-1:0] pend_a;
  logic [DW-1:0] ref_mem [1024];
  bit            ref_wr [1024];

  function automatic int pick(bit r0, bit r1);
    if (locked) return ((lockp == 0 ? r0 : r1) ? lockp : -1);
    if (r0 && r1) return (lastw == 0) ? 1 : 0;
    if (r0) return 0;
    if (r1) return 1;
    return -1;
  endfunction

  always @(negedge clk) begin : mon
    int   w;
    txn_t t;
    if (!rst_n) begin
      ph = 1'b0; locked = 1'b0; lastw = 1;
    end else if (!ph) begin
      chk("idle_busy", busy, 0);
      chk("idle_ack0", ack0, 0);
      chk("idle_ack1", ack1, 0);
      w = pick(req0 && q0.size() > 0, req1 && q1.size() > 0);
      if (w < 0) begin
        chk("idle_m_we", m_we, 0);
        chk("idle_m_addr", m_addr, 0);
        chk("idle_m_din", m_din, 0);
      end else begin
        t = (w == 0) ? q0[0] : q1[0];
        chk("iss_m_we", m_we, t.we);
        chk("iss_m_addr", m_addr, t.a);
        chk("iss_m_din", m_din, t.d);
        exp_rd = t.we ? '0 : (ref_wr[t.a] ? ref_mem[t.a] : init_val(t.a));
        if (t.we) begin ref_mem[t.a] = t.d; ref_wr[t.a] = 1'b1; end
        if (!locked && t.lk) begin locked = 1'b1; lockp = w; end
        else if (locked && !t.lk) locked = 1'b0;
        lastw = w; pend = w; pend_a = t.a; ph = 1'b1;
      end
    end else begin
      chk("resp_busy", busy, 1);
      chk("resp_ack_own", pend == 0 ? ack0 : ack1, 1);
      chk("resp_ack_other", pend == 0 ? ack1 : ack0, 0);
      chk("resp_rdata_own", pend == 0 ? rdata0 : rdata1, exp_rd);
      chk("resp_rdata_other", pend == 0 ? rdata1 : rdata0, 0);
      chk("resp_m_we", m_we, 0);
      chk("resp_m_addr", m_addr, pend_a);
      if (pend == 0) void'(q0.pop_front()); else void'(q1.pop_front());
      alog.push_back('{pend, pend == 0 ? rdata0 : rdata1});
      ph = 1'b0;
    end
  end

  task automatic access(input int p, input bit we, input bit lk,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n = 0;
    if (p == 0) begin
      we0 = we; lock0 = lk; addr0 = a; wdata0 = d; req0 = 1'b1; q0.push_back('{we, lk, a, d});
    end else begin
      we1 = we; lock1 = lk; addr1 = a; wdata1 = d; req1 = 1'b1; q1.push_back('{we, lk, a, d});
    end
    do begin
      @(negedge clk);
      n++;
    end while (!(p == 0 ? ack0 : ack1) && n < 300);
    if (n >= 300) begin
      tests++; fails++;
      $display("FAIL timeout_port%0d: no ack within %0d cycles", p, n);
    end
    @(posedge clk); #1;
    if (p == 0) req0 = 1'b0; else req1 = 1'b0;
  endtask

  task automatic rnd_port(input int p, input int n);
    bit inl = 1'b0;
    bit lk;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      if (i == n - 1) lk = 1'b0;
      else if (inl)   lk = 1'($urandom_range(0, 1));
      else            lk = ($urandom_range(0, 3) == 0);
      access(p, 1'($urandom_range(0, 1)), lk, 10'($urandom_range(0, 7)), $urandom);
      inl = lk;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    logic [DW-1:0] x;
    repeat (3) @(posedge clk); #1;
    chk("rst_busy", busy, 0);
    chk("rst_ack0", ack0, 0);
    chk("rst_ack1", ack1, 0);
    chk("rst_m_we", m_we, 0);
    chk("rst_m_addr", m_addr, 0);
    chk("rst_m_din", m_din, 0);
    chk("rst_rdata0", rdata0, 0);
    chk("rst_rdata1", rdata1, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Port 0 write then read back.
    access(0, 1'b1, 1'b0, 10'h010, 32'hDEADBEEF);
    access(0, 1'b0, 1'b0, 10'h010, $urandom);
    chk("t1_port", alog[alog.size()-1].p, 0);
    chk("t1_rdata", alog[alog.size()-1].rd, 32'hDEADBEEF);

    // Fixed priority: port 0 always wins.
    f_req0 = 1'b1; f_req1 = 1'b1; cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("fx_ack1", f_ack1, 0);
      chk("fx_m_we", f_m_we, 0);
      if (f_ack0) begin
        cnt++;
        chk("fx_rdata0", f_rdata0, 32'd5);
        chk("fx_rdata1", f_rdata1, 0);
      end
    end
    chk("fx_ack0_count", cnt, 10);
    @(posedge clk); #1;
    f_req0 = 1'b0; f_req1 = 1'b0;

    // Round-robin with both ports streaming reads.
    alog.delete();
    fork
      repeat (4) access(0, 1'b0, 1'b0, 10'h021, $urandom);
      repeat (4) access(1, 1'b0, 1'b0, 10'h022, $urandom);
    join
    chk("rr_count", alog.size(), 8);
    for (int i = 1; i < alog.size(); i++) chk("rr_alternate", alog[i].p, 1 - alog[i-1].p);

    // Locked read-modify-write on port 1 while port 0 waits.
    alog.delete();
    x = $urandom;
    fork
      begin
        access(1, 1'b0, 1'b1, 10'h020, $urandom);
        access(1, 1'b1, 1'b0, 10'h020, x);
      end
      begin
        @(posedge clk); #1;
        access(0, 1'b0, 1'b0, 10'h020, $urandom);
      end
    join
    chk("lock_count", alog.size(), 3);
    chk("lock_order0", alog[0].p, 1);
    chk("lock_order1", alog[1].p, 1);
    chk("lock_order2", alog[2].p, 0);
    chk("lock_rdata", alog[2].rd, x);

    // Port 1 write alone.
    alog.delete();
    access(1, 1'b1, 1'b0, 10'h155, 32'hCAFE_F00D);
    chk("p1w_rdata", alog[0].rd, 0);
    chk("p1w_port", alog[0].p, 1);

    // Reset during RESP of a port 0 read.
    we0 = 1'b0; lock0 = 1'b0; addr0 = 10'h003; wdata0 = $urandom; req0 = 1'b1;
    q0.push_back('{1'b0, 1'b0, 10'h003, wdata0});
    @(posedge clk); #2;
    chk("rst_mid_in_resp", ack0, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_m_we", m_we, 0);
    chk("rst_mid_ack0", ack0, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_rdata0", rdata0, 0);
    req0 = 1'b0;
    q0.delete();
    alog.delete();
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("post_rst_busy", busy, 0);
    chk("post_rst_ack0", ack0, 0);
    fork
      access(0, 1'b0, 1'b0, 10'h004, $urandom);
      access(1, 1'b0, 1'b0, 10'h005, $urandom);
    join
    chk("post_rst_first", alog[0].p, 0);

    // Randomized traffic with locks on both ports.
    fork
      rnd_port(0, 40);
      rnd_port(1, 40);
    join
    repeat (3) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
